// File: rtl/isa_pkg.sv
// Shared ISA definitions for the ARM-subset pipeline: field encodings, control
// bundle layout, and the controller / condition-check decode functions.
package isa_pkg;

    localparam int CTRL_BITS = 9;

    // Bit positions inside the control bundle {WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, B, S}
    localparam int CTRL_WB_EN   = 8;
    localparam int CTRL_MEM_R   = 7;
    localparam int CTRL_MEM_W   = 6;
    localparam int CTRL_CMD_MSB = 5;
    localparam int CTRL_CMD_LSB = 2;
    localparam int CTRL_B       = 1;
    localparam int CTRL_S       = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
        OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        MODE_ALU = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10
    } mode_e;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000, CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic [3:0] exe_cmd;
        logic       b;
        logic       s;
    } ctrl_t;

    // Memory ops only decode with the ADD opcode (address = Rn + offset).
    function automatic ctrl_t controller(input logic [1:0] mode,
                                         input logic [3:0] opcode,
                                         input logic       s);
        ctrl_t c;
        c = '0;
        case (mode)
            MODE_ALU: begin
                c.s = s;
                case (opcode)
                    OP_MOV: begin c.wb_en = 1'b1; c.exe_cmd = CMD_MOV; end
                    OP_MVN: begin c.wb_en = 1'b1; c.exe_cmd = CMD_MVN; end
                    OP_ADD: begin c.wb_en = 1'b1; c.exe_cmd = CMD_ADD; end
                    OP_ADC: begin c.wb_en = 1'b1; c.exe_cmd = CMD_ADC; end
                    OP_SUB: begin c.wb_en = 1'b1; c.exe_cmd = CMD_SUB; end
                    OP_SBC: begin c.wb_en = 1'b1; c.exe_cmd = CMD_SBC; end
                    OP_AND: begin c.wb_en = 1'b1; c.exe_cmd = CMD_AND; end
                    OP_ORR: begin c.wb_en = 1'b1; c.exe_cmd = CMD_ORR; end
                    OP_EOR: begin c.wb_en = 1'b1; c.exe_cmd = CMD_EOR; end
                    OP_CMP: c.exe_cmd = CMD_SUB;
                    OP_TST: c.exe_cmd = CMD_AND;
                    default: c = '0;
                endcase
            end
            MODE_MEM: begin
                if (opcode == OP_ADD) begin
                    c.exe_cmd = CMD_ADD;
                    if (s) begin
                        c.wb_en    = 1'b1;
                        c.mem_r_en = 1'b1;
                    end else begin
                        c.mem_w_en = 1'b1;
                    end
                end
            end
            MODE_BR: c.b = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // sr = {N, Z, C, V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v, ok;
        n = sr[3];
        z = sr[2];
        c = sr[1];
        v = sr[0];
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = ~z;
            COND_CS: ok = c;
            COND_CC: ok = ~c;
            COND_MI: ok = n;
            COND_PL: ok = ~n;
            COND_VS: ok = v;
            COND_VC: ok = ~v;
            COND_HI: ok = c & ~z;
            COND_LS: ok = ~c | z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = ~z & (n == v);
            COND_LE: ok = z | (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports; a same-cycle write-back
// to the read index is bypassed to the read data.
module regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREG];

    // Reset dominates a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with built-in ID/EX register: field decode, register read with
// write-back bypass, RAW hazard detection against EX/MEM, and condition gating.
module id_stage_pipe
    import isa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int CTRL_W = 9,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        Sr,
    input  logic              flush,
    input  logic              exe_wb_en,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              WB_EN,
    input  logic [REG_AW-1:0] WB_DES,
    input  logic [DATA_W-1:0] WB_Value,
    output logic              hazard,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_Val_Rn,
    output logic [DATA_W-1:0] ex_Val_Rm,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_operand,
    output logic [23:0]       ex_Signed_imm_24,
    output logic [REG_AW-1:0] ex_Dest,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2,
    output logic [DATA_W-1:0] ex_pc
);

    logic [3:0]  cond, opcode;
    logic [1:0]  mode;
    logic        imm_bit, s_bit;
    logic [3:0]  rn_f, rd_f, rm_f;

    assign cond    = instruction[31:28];
    assign mode    = instruction[27:26];
    assign imm_bit = instruction[25];
    assign opcode  = instruction[24:21];
    assign s_bit   = instruction[20];
    assign rn_f    = instruction[19:16];
    assign rd_f    = instruction[15:12];
    assign rm_f    = instruction[3:0];

    logic [CTRL_BITS-1:0] ctrl;
    logic                 cond_ok;

    assign ctrl    = controller(mode, opcode, s_bit);
    assign cond_ok = cond_check(cond, Sr);

    // Stores read Rd as the data operand, so src2 switches to Rd for them.
    logic [REG_AW-1:0] src1, src2;
    assign src1 = REG_AW'(rn_f);
    assign src2 = ctrl[CTRL_MEM_W] ? REG_AW'(rd_f) : REG_AW'(rm_f);

    logic uses_src1, uses_src2, is_mov;
    assign is_mov    = (opcode == OP_MOV) || (opcode == OP_MVN);
    assign uses_src1 = ~ctrl[CTRL_B] & (~is_mov | (mode != MODE_ALU));
    assign uses_src2 = (~imm_bit & (mode == MODE_ALU) & ~ctrl[CTRL_B]) | ctrl[CTRL_MEM_W];

    logic src1_hit, src2_hit;
    assign src1_hit = uses_src1 & ((exe_wb_en & (src1 == exe_dest)) |
                                   (mem_wb_en & (src1 == mem_dest)));
    assign src2_hit = uses_src2 & ((exe_wb_en & (src2 == exe_dest)) |
                                   (mem_wb_en & (src2 == mem_dest)));
    assign hazard   = in_valid & (src1_hit | src2_hit);

    logic [DATA_W-1:0] val_rn, val_rm;

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (WB_EN),
        .waddr  (WB_DES),
        .wdata  (WB_Value),
        .raddr1 (src1),
        .raddr2 (src2),
        .rdata1 (val_rn),
        .rdata2 (val_rm)
    );

    // Reset, flush and stall all load the same all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || flush || hazard) begin
            ex_valid         <= 1'b0;
            ex_ctrl          <= '0;
            ex_Val_Rn        <= '0;
            ex_Val_Rm        <= '0;
            ex_imm           <= 1'b0;
            ex_shift_operand <= '0;
            ex_Signed_imm_24 <= '0;
            ex_Dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_pc            <= '0;
        end else begin
            ex_valid         <= in_valid;
            ex_ctrl          <= (in_valid && cond_ok) ? CTRL_W'(ctrl) : '0;
            ex_Val_Rn        <= val_rn;
            ex_Val_Rm        <= val_rm;
            ex_imm           <= imm_bit;
            ex_shift_operand <= instruction[11:0];
            ex_Signed_imm_24 <= instruction[23:0];
            ex_Dest          <= REG_AW'(rd_f);
            ex_src1          <= src1;
            ex_src2          <= src2;
            ex_pc            <= pc_in;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed checks of the decode stage followed by randomized traffic compared
// against a table-driven behavioural model of decode, hazard and the ID/EX slot.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, exe_wb_en, mem_wb_en, WB_EN, hazard;
    logic [31:0] instruction, pc_in, WB_Value;
    logic [3:0]  Sr, exe_dest, mem_dest, WB_DES;
    logic        ex_valid, ex_imm;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_Val_Rn, ex_Val_Rm, ex_pc;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_Signed_imm_24;
    logic [3:0]  ex_Dest, ex_src1, ex_src2;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mregs [16];
    int          alu_cmd [16];
    bit          alu_wb [16];
    bit          alu_ok [16];

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .pc_in(pc_in), .Sr(Sr), .flush(flush), .exe_wb_en(exe_wb_en),
        .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
        .WB_EN(WB_EN), .WB_DES(WB_DES), .WB_Value(WB_Value), .hazard(hazard),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_Val_Rn(ex_Val_Rn),
        .ex_Val_Rm(ex_Val_Rm), .ex_imm(ex_imm), .ex_shift_operand(ex_shift_operand),
        .ex_Signed_imm_24(ex_Signed_imm_24), .ex_Dest(ex_Dest), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Conditions come in complementary pairs: odd codes negate the even one.
    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c == 4'hE;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [31:0] rd_model(input logic [3:0] idx);
        return (WB_EN && WB_DES == idx) ? WB_Value : mregs[idx];
    endfunction

    // One clock: check hazard before the edge, then the registered bundle after it.
    task automatic cycle();
        logic [3:0] op, rn, rd, rm, s2;
        logic [1:0] md;
        bit wb, mr, mw, br, s, u1, u2, hz;
        int cmd;
        logic [8:0] ctl;
        bit n_valid, n_imm;
        logic [8:0] n_ctrl;
        logic [31:0] n_rn, n_rm, n_pc;
        logic [11:0] n_sh;
        logic [23:0] n_si;
        logic [3:0] n_dest, n_s1, n_s2;
        #1;
        md = instruction[27:26]; op = instruction[24:21];
        rn = instruction[19:16]; rd = instruction[15:12]; rm = instruction[3:0];
        wb = 0; mr = 0; mw = 0; br = 0; s = 0; cmd = 0;
        if (md == 2'd0 && alu_ok[op]) begin
            wb = alu_wb[op]; cmd = alu_cmd[op]; s = instruction[20];
        end else if (md == 2'd1 && op == 4'd4) begin
            cmd = 2;
            if (instruction[20]) begin wb = 1; mr = 1; end else mw = 1;
        end else if (md == 2'd2) begin
            br = 1;
        end
        ctl = {wb, mr, mw, 4'(cmd), br, s};
        s2  = mw ? rd : rm;
        u1  = !br && (!(op == 4'd13 || op == 4'd15) || md != 2'd0);
        u2  = (!instruction[25] && md == 2'd0 && !br) || mw;
        hz  = in_valid && ((u1 && ((exe_wb_en && rn == exe_dest) || (mem_wb_en && rn == mem_dest))) ||
                           (u2 && ((exe_wb_en && s2 == exe_dest) || (mem_wb_en && s2 == mem_dest))));
        chk("hazard", hazard, hz);
        if (rst || flush || hz) begin
            n_valid = 0; n_ctrl = 0; n_rn = 0; n_rm = 0; n_imm = 0; n_sh = 0;
            n_si = 0; n_dest = 0; n_s1 = 0; n_s2 = 0; n_pc = 0;
        end else begin
            n_valid = in_valid;
            n_ctrl  = (in_valid && cond_model(instruction[31:28], Sr)) ? ctl : 9'd0;
            n_rn = rd_model(rn); n_rm = rd_model(s2); n_imm = instruction[25];
            n_sh = instruction[11:0]; n_si = instruction[23:0];
            n_dest = rd; n_s1 = rn; n_s2 = s2; n_pc = pc_in;
        end
        if (rst) for (int i = 0; i < 16; i++) mregs[i] = 0;
        else if (WB_EN) mregs[WB_DES] = WB_Value;
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid, n_valid);
        chk("ex_ctrl", ex_ctrl, n_ctrl);
        chk("ex_Val_Rn", ex_Val_Rn, n_rn);
        chk("ex_Val_Rm", ex_Val_Rm, n_rm);
        chk("ex_imm", ex_imm, n_imm);
        chk("ex_shift_operand", ex_shift_operand, n_sh);
        chk("ex_Signed_imm_24", ex_Signed_imm_24, n_si);
        chk("ex_Dest", ex_Dest, n_dest);
        chk("ex_src1", ex_src1, n_s1);
        chk("ex_src2", ex_src2, n_s2);
        chk("ex_pc", ex_pc, n_pc);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; instruction = 0; pc_in = 0; Sr = 0; flush = 0;
        exe_wb_en = 0; mem_wb_en = 0; exe_dest = 0; mem_dest = 0;
        WB_EN = 0; WB_DES = 0; WB_Value = 0;
    endtask

    task automatic def_op(input int op, input int cmd, input bit wb);
        alu_ok[op] = 1; alu_cmd[op] = cmd; alu_wb[op] = wb;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] cnd, rn, rd, rm, op;
        logic s;
        cnd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
        rn = 4'($urandom_range(0, 4)); rd = 4'($urandom_range(0, 4));
        rm = 4'($urandom_range(0, 4)); op = 4'($urandom); s = 1'($urandom);
        case ($urandom_range(0, 4))
            0: return {cnd, 2'b00, 1'b0, op, s, rn, rd, 8'($urandom), rm};
            1: return {cnd, 2'b00, 1'b1, op, s, rn, rd, 12'($urandom)};
            2: return {cnd, 2'b01, 1'b0, ($urandom_range(0, 5) == 0) ? op : 4'h4, s, rn, rd, 12'($urandom)};
            3: return {cnd, 2'b10, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] ADD_R1_R2_R3 = 32'hE0821003;

    initial begin
        for (int i = 0; i < 16; i++) begin alu_ok[i] = 0; alu_cmd[i] = 0; alu_wb[i] = 0; end
        def_op(13, 1, 1); def_op(15, 9, 1); def_op(4, 2, 1); def_op(5, 3, 1);
        def_op(2, 4, 1);  def_op(6, 5, 1);  def_op(0, 6, 1); def_op(12, 7, 1);
        def_op(1, 8, 1);  def_op(10, 4, 0); def_op(8, 6, 0);
        for (int i = 0; i < 16; i++) mregs[i] = 0;

        // Reset with a concurrent write to R6 that must be dropped
        idle(); rst = 1; WB_EN = 1; WB_DES = 6; WB_Value = 32'h99;
        cycle(); cycle();
        idle();
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_hazard", hazard, 0);

        idle(); WB_EN = 1; WB_DES = 2; WB_Value = 5; cycle();
        WB_DES = 3; WB_Value = 7; cycle();
        idle(); in_valid = 1; instruction = 32'hE0861006; cycle();
        chk("rst_write_ignored", ex_Val_Rn, 0);

        idle(); in_valid = 1; instruction = ADD_R1_R2_R3; pc_in = 32'h104; cycle();
        chk("add_rn", ex_Val_Rn, 5);
        chk("add_rm", ex_Val_Rm, 7);
        chk("add_dest", ex_Dest, 1);
        chk("add_valid", ex_valid, 1);
        chk("add_ctrl", ex_ctrl, 9'h108);

        exe_dest = 2; exe_wb_en = 1;
        #1 chk("exe_raw_hazard", hazard, 1);
        cycle();
        chk("exe_raw_bubble", ex_valid, 0);
        instruction = 32'hE3A21005;
        #1 chk("mov_imm_no_hazard", hazard, 0);
        cycle();
        chk("mov_imm_valid", ex_valid, 1);

        idle(); in_valid = 1; instruction = 32'hE4854000; mem_dest = 4; mem_wb_en = 1;
        #1 chk("str_rd_hazard", hazard, 1);
        cycle();

        idle(); in_valid = 1; instruction = ADD_R1_R2_R3;
        WB_EN = 1; WB_DES = 3; WB_Value = 32'hDEAD; cycle();
        chk("bypass_rm", ex_Val_Rm, 32'hDEAD);

        idle(); in_valid = 1; instruction = 32'h00821003; Sr = 4'b0000; cycle();
        chk("eq_fail_valid", ex_valid, 1);
        chk("eq_fail_ctrl", ex_ctrl, 0);

        idle(); in_valid = 1; instruction = ADD_R1_R2_R3; flush = 1;
        #1 chk("flush_no_hazard", hazard, 0);
        cycle();
        chk("flush_valid", ex_valid, 0);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            instruction = rand_instr();
            pc_in = $urandom; Sr = 4'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            exe_wb_en = 1'($urandom); mem_wb_en = 1'($urandom);
            exe_dest = 4'($urandom_range(0, 4)); mem_dest = 4'($urandom_range(0, 4));
            WB_EN = 1'($urandom); WB_DES = 4'($urandom_range(0, 5)); WB_Value = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
